// File: rtl/eth_tx_pkg.sv
// Shared types for the Ethernet TX path: frame types, scheduler FSM states and
// requester indices, plus a one-hot to frame-type helper.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ARP  = 2'd1,
    ICMP = 2'd2,
    UDP  = 2'd3
  } frame_type_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  localparam int REQ_ARP  = 0;
  localparam int REQ_ICMP = 1;
  localparam int REQ_UDP  = 2;

  function automatic frame_type_t onehot_to_frame(input logic [2:0] oh);
    frame_type_t ft;
    ft = NONE;
    if (oh[REQ_ARP])       ft = ARP;
    else if (oh[REQ_ICMP]) ft = ICMP;
    else if (oh[REQ_UDP])  ft = UDP;
    return ft;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Handshake bundle between the TX frame scheduler, its three frame sources,
// the header/data generators and the TX output mux.
interface tx_frame_scheduler_if;
  import eth_tx_pkg::*;

  logic [2:0]  req;
  logic [2:0]  ack;
  logic [2:0]  grant;
  frame_type_t frame_sel;
  logic        tx_start;
  logic        tx_frame_done;

  modport master (
    input  req,
    input  tx_frame_done,
    output ack,
    output grant,
    output frame_sel,
    output tx_start
  );

  modport slave (
    output req,
    output tx_frame_done,
    input  ack,
    input  grant,
    input  frame_sel,
    input  tx_start
  );

endinterface

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin pick; the search starts at the requester
// after the previous owner. Output is one-hot, or zero when nothing requests.
module rr_arbiter3
  import eth_tx_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [2:0] i_last,
  output logic [2:0] o_gnt
);

  always_comb begin
    o_gnt = 3'b000;
    if (i_last[REQ_ARP]) begin
      if (i_req[REQ_ICMP])      o_gnt[REQ_ICMP] = 1'b1;
      else if (i_req[REQ_UDP])  o_gnt[REQ_UDP]  = 1'b1;
      else if (i_req[REQ_ARP])  o_gnt[REQ_ARP]  = 1'b1;
    end else if (i_last[REQ_ICMP]) begin
      if (i_req[REQ_UDP])       o_gnt[REQ_UDP]  = 1'b1;
      else if (i_req[REQ_ARP])  o_gnt[REQ_ARP]  = 1'b1;
      else if (i_req[REQ_ICMP]) o_gnt[REQ_ICMP] = 1'b1;
    end else begin
      // UDP owned last (also the reset owner), so ARP is searched first
      if (i_req[REQ_ARP])       o_gnt[REQ_ARP]  = 1'b1;
      else if (i_req[REQ_ICMP]) o_gnt[REQ_ICMP] = 1'b1;
      else if (i_req[REQ_UDP])  o_gnt[REQ_UDP]  = 1'b1;
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin owner selection for the shared Ethernet TX pipeline: grants one
// frame source, fires tx_start, holds until tx_frame_done or watchdog abort.
module tx_frame_scheduler
  import eth_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_W          = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 i_sched_en,
  tx_frame_scheduler_if.master bus,
  output logic                 o_busy,
  output logic                 o_timeout_err,
  output logic [CNT_W-1:0]     o_frames_sent,
  output logic [7:0]           o_timeout_cnt
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LAST = (HOLDOFF_CYCLES > 0) ? HO_W'(HOLDOFF_CYCLES - 1) : '0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_grant;
  logic [2:0]          r_last_grant;
  logic [2:0]          r_ack;
  frame_type_t         r_frame_sel;
  logic [CNT_W-1:0]    r_frames_sent;
  logic [7:0]          r_timeout_cnt;
  logic [WD_W-1:0]     r_wd;
  logic [HO_W-1:0]     r_ho;
  logic [2:0]          w_pick;
  logic                w_arb_go;
  logic                w_done;
  logic                w_expire;
  logic                w_ho_end;

  rr_arbiter3 u_arb (
    .i_req  (bus.req),
    .i_last (r_last_grant),
    .o_gnt  (w_pick)
  );

  assign w_arb_go = i_sched_en && (bus.req != 3'b000);
  assign w_done   = (r_state == WAIT_DONE) && bus.tx_frame_done;
  // Done in the expiry cycle takes priority over the abort
  assign w_expire = (r_state == WAIT_DONE) && !bus.tx_frame_done && (r_wd == '0);
  assign w_ho_end = (HOLDOFF_CYCLES == 0) || (r_ho == HO_LAST);

  // ---- state register ----
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_arb_go)            w_next = START;
      START:                              w_next = WAIT_DONE;
      WAIT_DONE: if (w_done || w_expire)  w_next = HOLDOFF;
      HOLDOFF:   if (w_ho_end)            w_next = IDLE;
      default:                            w_next = IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    bus.tx_start  = 1'b0;
    o_busy        = 1'b0;
    o_timeout_err = 1'b0;
    if (r_state == START) bus.tx_start = 1'b1;
    if (r_state != IDLE)  o_busy       = 1'b1;
    if (w_expire)         o_timeout_err = 1'b1;
  end

  // ---- ownership, ack and statistics ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_grant       <= 3'b000;
      r_frame_sel   <= NONE;
      r_last_grant  <= 3'b100;
      r_ack         <= 3'b000;
      r_frames_sent <= '0;
      r_timeout_cnt <= 8'd0;
    end else begin
      r_ack <= 3'b000;
      unique case (r_state)
        IDLE: begin
          if (w_arb_go) begin
            r_grant     <= w_pick;
            r_frame_sel <= onehot_to_frame(w_pick);
          end
        end
        WAIT_DONE: begin
          if (w_done || w_expire) begin
            r_last_grant <= r_grant;
            r_grant      <= 3'b000;
            r_frame_sel  <= NONE;
          end
          if (w_done) begin
            r_ack         <= r_grant;
            r_frames_sent <= r_frames_sent + CNT_W'(1);
          end
          if (w_expire) r_timeout_cnt <= sat_inc8(r_timeout_cnt);
        end
        default: ;
      endcase
    end
  end

  // ---- watchdog and holdoff counters ----
  always_ff @(posedge aclk) begin
    if (r_state == START)          r_wd <= WD_LOAD;
    else if (r_state == WAIT_DONE) r_wd <= r_wd - WD_W'(1);
    if (r_state == HOLDOFF)        r_ho <= r_ho + HO_W'(1);
    else                           r_ho <= '0;
  end

  assign bus.grant     = r_grant;
  assign bus.frame_sel = r_frame_sel;
  assign bus.ack       = r_ack;
  assign o_frames_sent = r_frames_sent;
  assign o_timeout_cnt = r_timeout_cnt;

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Arbitrates between the three TX frame sources (ARP reply, ICMP echo reply, UDP transmit) that share the single Ethernet TX pipeline.
- Picks one requester round-robin.
- Presents the frame type to the header and data generators.
- Fires the one-cycle start into the preamble/SFD generator.
- Holds the selection until the TX output mux reports tx_frame_done.
- Guards each frame with a watchdog.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles from tx_start to tx_frame_done before abort (must be ≥ 2).
HOLDOFF_CYCLES, 2, idle cycles after each frame before next arbitration (0 allowed).
CNT_W, 16, width of frames_sent counter.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
sched_en  in  1  1 = arbitration allowed; 0 = no new grants, in-flight frame completes
req  in  3  level requests, bit0 ARP, bit1 ICMP, bit2 UDP; held until ack
ack  out  3  one-cycle pulse to the granted requester on frame completion
grant  out  3  one-hot current owner, 0 when idle
frame_sel  out  2  frame_type_t of current frame (NONE/ARP/ICMP/UDP)
tx_start  out  1  one-cycle pulse to preamble/SFD generator
tx_frame_done  in  1  end-of-frame pulse from TX output mux
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse on watchdog abort
frames_sent  out  CNT_W  completed-frame count, wraps
timeout_cnt  out  8  watchdog abort count, saturates at 255

Behaviour:
Reset values:
- All outputs 0; frame_sel = NONE.
- last_grant = UDP, so ARP wins first.
- State IDLE.

State machine (state_t): IDLE, START, WAIT_DONE, HOLDOFF.

IDLE:
- If sched_en and req != 0, select the winner by round-robin starting at the bit after last_grant (ARP→ICMP→UDP→ARP).
- Register grant and frame_sel; go to START.
- Grant appears the cycle after req is sampled.

START:
- tx_start = 1 for exactly this cycle.
- Load watchdog with TIMEOUT_CYCLES−1; go to WAIT_DONE.

WAIT_DONE:
- On tx_frame_done:
  - ack[granted] = 1 the next cycle.
  - frames_sent += 1.
  - last_grant = grant; go to HOLDOFF.
- Else, when the watchdog reaches 0:
  - timeout_err pulse; timeout_cnt += 1 (saturating).
  - last_grant = grant; no ack; go to HOLDOFF.
- Else decrement the watchdog.
- If tx_frame_done and watchdog expiry occur in the same cycle, done wins.

HOLDOFF:
- Clear grant and frame_sel = NONE on entry.
- Count HOLDOFF_CYCLES, then go to IDLE.
- If HOLDOFF_CYCLES = 0, spend exactly one cycle in HOLDOFF.

Boundary rules:
- grant and frame_sel are stable from START through WAIT_DONE.
- Requester deasserting req mid-frame: ignored; the frame completes and ack is still pulsed.
- tx_frame_done outside WAIT_DONE is ignored.
- sched_en falling mid-frame does not abort.
- A timed-out requester keeps req high and is retried only after the other pending requesters have been served (rotation still advances).
- Reset mid-frame: immediate return to IDLE with all outputs 0; counters cleared.

Latency:
- Minimum req→tx_start is 2 cycles.
- Back-to-back frame gap after tx_frame_done is HOLDOFF_CYCLES + 2 cycles.

Decomposition:
Package eth_tx_pkg holds:
- frame_type_t enum: NONE = 2'd0, ARP = 2'd1, ICMP = 2'd2, UDP = 2'd3.
- state_t.
- Requester index constants REQ_ARP = 0, REQ_ICMP = 1, REQ_UDP = 2.

Sub-module rr_arbiter3 (combinational round-robin pick from req and last_grant, one-hot output) is natural and reusable on the RX side.

Test Plan:
1. req = 3'b001 only → grant = 001 at cycle 2, frame_sel = ARP, one tx_start; tx_frame_done after 80 cycles → ack = 001 one cycle, frames_sent = 1, grant = 0 during holdoff.
2. req = 3'b111 held, each frame ends via tx_frame_done → grant order ARP, ICMP, UDP, ARP; frames_sent = 4; gap between done and next tx_start = 4 cycles (HOLDOFF = 2).
3. TIMEOUT_CYCLES = 16, req = 3'b100, no tx_frame_done → timeout_err pulses 16 cycles after tx_start, timeout_cnt = 1, no ack; with req = 3'b101, ARP is granted next.
4. tx_frame_done on the exact watchdog-expiry cycle → ack pulses, timeout_err stays 0, frames_sent increments.
5. sched_en = 0 with req = 3'b010 → no tx_start for 100 cycles; raise sched_en → grant 010 within 2 cycles. Drop sched_en mid-frame → frame still completes with ack.
6. aresetn low during WAIT_DONE → next cycle grant = 0, busy = 0, frame_sel = NONE, counters = 0; a tx_frame_done arriving afterward produces no ack.
